// File: rtl/race_sequencer.sv
// Race controller: game state bus, countdown display, centisecond race timer
// and winner resolution from the two physics engines' finish flags.
module race_sequencer #(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned COUNTDOWN_SEC = 3,
  parameter int unsigned TIME_MAX      = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        p1_ready,
  input  logic        p2_ready,
  input  logic        p1_finish,
  input  logic        p2_finish,
  output logic [2:0]  state,
  output logic [1:0]  countdown,
  output logic [13:0] race_time,
  output logic [1:0]  winner
);

  localparam int unsigned PRESCALE = CLK_FREQ / 100;
  localparam int unsigned CS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CS_W-1:0] CS_LAST = CS_W'(PRESCALE - 1);
  localparam logic [13:0]     T_MAX   = 14'(TIME_MAX);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETTING   = 3'd1;
  localparam logic [2:0] S_COUNTDOWN = 3'd3;
  localparam logic [2:0] S_RACING    = 3'd4;
  localparam logic [2:0] S_PAUSE     = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  logic            start_q, pause_q;
  logic [CS_W-1:0] cs_cnt, cs_cnt_d;
  logic [6:0]      sec_cnt, sec_cnt_d;
  logic [2:0]      state_d;
  logic [1:0]      countdown_d, winner_d;
  logic [13:0]     race_time_d;

  logic start_e, pause_e, timing_c, cs_tick, sec_tick;

  assign start_e  = btn_start & ~start_q;
  assign pause_e  = btn_pause & ~pause_q;
  assign timing_c = (state == S_COUNTDOWN) || (state == S_RACING);
  assign cs_tick  = timing_c && (cs_cnt == CS_LAST);
  assign sec_tick = (state == S_COUNTDOWN) && cs_tick && (sec_cnt == 7'd99);

  // Next-state and next-datapath logic
  always_comb begin
    state_d     = state;
    countdown_d = countdown;
    race_time_d = race_time;
    winner_d    = winner;
    cs_cnt_d    = cs_cnt;
    sec_cnt_d   = sec_cnt;

    // Prescaler runs only while timing; it simply holds in PAUSE
    if (timing_c) cs_cnt_d = cs_tick ? '0 : cs_cnt + CS_W'(1);

    case (state)
      S_IDLE: begin
        winner_d    = 2'd0;
        race_time_d = 14'd0;
        countdown_d = 2'd0;
        if (start_e) state_d = S_SETTING;
      end
      S_SETTING: begin
        if (start_e && p1_ready && p2_ready) begin
          state_d     = S_COUNTDOWN;
          countdown_d = 2'(COUNTDOWN_SEC);
          race_time_d = 14'd0;
          cs_cnt_d    = '0;
          sec_cnt_d   = 7'd0;
        end
      end
      S_COUNTDOWN: begin
        if (cs_tick) sec_cnt_d = sec_tick ? 7'd0 : sec_cnt + 7'd1;
        if (sec_tick) begin
          if (countdown <= 2'd1) begin
            countdown_d = 2'd0;
            state_d     = S_RACING;
          end else begin
            countdown_d = countdown - 2'd1;
          end
        end
      end
      S_RACING: begin
        // A finish wins over both the pending tick and a pause request
        if (p1_finish || p2_finish) begin
          state_d  = S_FINISH;
          winner_d = {p2_finish, p1_finish};
        end else begin
          if (cs_tick && (race_time < T_MAX)) race_time_d = race_time + 14'd1;
          if (pause_e) state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (start_e)      state_d = S_IDLE;
        else if (pause_e) state_d = S_RACING;
      end
      S_FINISH: begin
        if (start_e) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Button history resets high so a button held through reset makes no edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      countdown <= 2'd0;
      race_time <= 14'd0;
      winner    <= 2'd0;
      cs_cnt    <= '0;
      sec_cnt   <= 7'd0;
      start_q   <= 1'b1;
      pause_q   <= 1'b1;
    end else begin
      state     <= state_d;
      countdown <= countdown_d;
      race_time <= race_time_d;
      winner    <= winner_d;
      cs_cnt    <= cs_cnt_d;
      sec_cnt   <= sec_cnt_d;
      start_q   <= btn_start;
      pause_q   <= btn_pause;
    end
  end

endmodule

// File: tb/tb_race_sequencer.sv
// Bench for race_sequencer: directed race scenarios plus random button traffic,
// checked every cycle against an elapsed-cycle model of the race rules.
module tb_race_sequencer;

  localparam int unsigned CLK_FREQ = 1000;
  localparam int unsigned CD_SEC   = 3;
  localparam int unsigned TMAX     = 300;
  localparam int unsigned P        = CLK_FREQ / 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_start = 1'b0, btn_pause = 1'b0;
  logic        p1_ready = 1'b1, p2_ready = 1'b1;
  logic        p1_finish = 1'b0, p2_finish = 1'b0;
  logic [2:0]  state;
  logic [1:0]  countdown;
  logic [13:0] race_time;
  logic [1:0]  winner;

  int n_checks = 0;
  int n_errors = 0;

  race_sequencer #(.CLK_FREQ(CLK_FREQ), .COUNTDOWN_SEC(CD_SEC), .TIME_MAX(TMAX)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_pause(btn_pause),
    .p1_ready(p1_ready), .p2_ready(p2_ready), .p1_finish(p1_finish), .p2_finish(p2_finish),
    .state(state), .countdown(countdown), .race_time(race_time), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: progress expressed as cycles spent in countdown and in counted racing
  int m_state, m_cd, m_time, m_win;
  int cd_cyc, rc;
  bit ps, pp;

  task automatic model_reset();
    m_state = 0; m_cd = 0; m_time = 0; m_win = 0;
    cd_cyc = 0; rc = 0; ps = 1'b1; pp = 1'b1;
  endtask

  task automatic model_step();
    bit se, pe;
    se = btn_start && !ps;
    pe = btn_pause && !pp;
    ps = btn_start;
    pp = btn_pause;
    case (m_state)
      0: begin
        m_win = 0; m_time = 0; m_cd = 0;
        if (se) m_state = 1;
      end
      1: if (se && p1_ready && p2_ready) begin
        m_state = 3; m_cd = CD_SEC; cd_cyc = 0; rc = 0; m_time = 0;
      end
      3: begin
        cd_cyc++;
        if (cd_cyc >= int'(CD_SEC * CLK_FREQ)) begin
          m_state = 4; m_cd = 0;
        end else begin
          m_cd = int'(CD_SEC) - cd_cyc / int'(CLK_FREQ);
        end
      end
      4: begin
        if (p1_finish || p2_finish) begin
          m_state = 6;
          m_win = (p2_finish ? 2 : 0) + (p1_finish ? 1 : 0);
        end else begin
          rc++;
          m_time = (rc / int'(P) > int'(TMAX)) ? int'(TMAX) : rc / int'(P);
          if (pe) m_state = 5;
        end
      end
      5: begin
        if (se)      m_state = 0;
        else if (pe) m_state = 4;
      end
      6: if (se) m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin
    check("state",     int'(state),     m_state);
    check("countdown", int'(countdown), m_cd);
    check("race_time", int'(race_time), m_time);
    check("winner",    int'(winner),    m_win);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_start();
    btn_start = 1'b1; @(negedge clk);
    btn_start = 1'b0; @(negedge clk);
  endtask

  task automatic press_pause();
    btn_pause = 1'b1; @(negedge clk);
    btn_pause = 1'b0; @(negedge clk);
  endtask

  // From IDLE with both players ready, ends on the first RACING cycle
  task automatic to_racing();
    press_start();
    press_start();
    cyc(int'(CD_SEC * CLK_FREQ) - 1);
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(2);
    check("lit_reset_state", int'(state), 0);

    // Reset in the middle of a race, start held through release
    to_racing();
    cyc(570);
    check("lit_time57", int'(race_time), 57);
    btn_start = 1'b1;
    rst = 1'b1;
    #1;
    check("lit_rst_state", int'(state), 0);
    check("lit_rst_time", int'(race_time), 0);
    check("lit_rst_winner", int'(winner), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(5);
    check("lit_held_start", int'(state), 0);
    btn_start = 1'b0;
    cyc(2);

    // Countdown sequence
    press_start();
    check("lit_setting", int'(state), 1);
    press_start();
    check("lit_cd_state", int'(state), 3);
    check("lit_cd3", int'(countdown), 3);
    cyc(int'(CLK_FREQ) - 1);
    check("lit_cd2", int'(countdown), 2);
    cyc(int'(CLK_FREQ));
    check("lit_cd1", int'(countdown), 1);
    cyc(int'(CLK_FREQ));
    check("lit_racing", int'(state), 4);
    check("lit_cd0", int'(countdown), 0);

    // Timing, pause and resume of a partial period
    cyc(250 * int'(P));
    check("lit_time250", int'(race_time), 250);
    press_pause();
    check("lit_pause", int'(state), 5);
    cyc(500);
    check("lit_pause_hold", int'(race_time), 250);
    press_pause();
    check("lit_resume", int'(state), 4);
    cyc(7);
    check("lit_partial_pre", int'(race_time), 250);
    cyc(1);
    check("lit_partial_post", int'(race_time), 251);

    // Tie finish, then finish inputs wiggle
    p1_finish = 1'b1; p2_finish = 1'b1;
    cyc(1);
    check("lit_finish", int'(state), 6);
    check("lit_tie", int'(winner), 3);
    check("lit_fin_time", int'(race_time), 251);
    p1_finish = 1'b0;
    cyc(3);
    p2_finish = 1'b0; p1_finish = 1'b1;
    cyc(2);
    check("lit_tie_held", int'(winner), 3);
    p1_finish = 1'b0;
    press_start();
    check("lit_fin_idle", int'(state), 0);
    check("lit_fin_win0", int'(winner), 0);

    // Start ignored without both ready; simultaneous pause+start aborts
    p2_ready = 1'b0;
    press_start();
    press_start();
    check("lit_not_ready", int'(state), 1);
    p2_ready = 1'b1;
    press_start();
    cyc(int'(CD_SEC * CLK_FREQ) - 1);
    press_pause();
    check("lit_pause2", int'(state), 5);
    btn_start = 1'b1; btn_pause = 1'b1;
    cyc(1);
    check("lit_abort", int'(state), 0);
    btn_start = 1'b0; btn_pause = 1'b0;
    cyc(2);

    // Saturation at TIME_MAX and P2 win
    to_racing();
    cyc(int'(TMAX * P));
    check("lit_sat", int'(race_time), int'(TMAX));
    cyc(3 * int'(P));
    check("lit_sat_hold", int'(race_time), int'(TMAX));
    p2_finish = 1'b1;
    cyc(1);
    check("lit_p2_win", int'(winner), 2);
    check("lit_p2_time", int'(race_time), int'(TMAX));
    p2_finish = 1'b0;
    press_start();

    // Random traffic
    for (int i = 0; i < 30000; i++) begin
      btn_start = ($urandom_range(0, 299) == 0);
      btn_pause = ($urandom_range(0, 199) == 0);
      p1_ready  = ($urandom_range(0, 9) != 0);
      p2_ready  = ($urandom_range(0, 9) != 0);
      p1_finish = ($urandom_range(0, 2999) == 0);
      p2_finish = ($urandom_range(0, 2999) == 0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/race_sequencer.md
Name: race_sequencer

Overview:
Top-level race controller. It generates the shared 3-bit game `state` bus that drives both PhysicsEngine instances, the countdown display value and a race timer. It also resolves the winner from the two engines' `finish` outputs. It sits between the button debouncers / settings menu and the two physics engines plus the HUD renderer.

Parameters:
CLK_FREQ, 100_000_000, system clock in Hz; centisecond prescale = CLK_FREQ/100.
COUNTDOWN_SEC, 3, countdown start value in seconds (1..3).
TIME_MAX, 9999, race_time saturation value in centiseconds.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
btn_start  in  1  debounced start/confirm button, level; rising edge used
btn_pause  in  1  debounced pause button, level; rising edge used
p1_ready  in  1  player 1 settings confirmed, level
p2_ready  in  1  player 2 settings confirmed, level
p1_finish  in  1  finish output of player 1 engine, level
p2_finish  in  1  finish output of player 2 engine, level
state  out  3  game state: 0 IDLE, 1 SETTING, 3 COUNTDOWN, 4 RACING, 5 PAUSE, 6 FINISH
countdown  out  2  seconds remaining in COUNTDOWN, else 0
race_time  out  14  elapsed race time, centiseconds
winner  out  2  0 none, 1 P1, 2 P2, 3 tie

Behaviour:
- Reset (async): state=IDLE, countdown=0, race_time=0, winner=0, prescaler=0, sec_cnt=0. Button history regs reset to 1, so a button held through reset gives no edge.
- Edge detect: start_e = btn_start & ~start_q; pause_e likewise. History regs update every cycle.
- Prescaler: cs_cnt counts 0..CLK_FREQ/100-1; cs_tick is a one-cycle pulse at the terminal count.
  - Counts only in COUNTDOWN and RACING.
  - Holds its value in PAUSE, so a resume continues the partial period.
  - Cleared on entry to COUNTDOWN.
- sec_cnt 0..99 counts cs_tick in COUNTDOWN only; sec_tick is asserted when cs_tick and sec_cnt==99.
- State values 2 and 7 are never produced. If reached (SEU), the next cycle goes to IDLE.
- IDLE:
  - start_e -> SETTING.
  - Every cycle in IDLE forces winner=0, race_time=0 and countdown=0.
- SETTING:
  - start_e while p1_ready & p2_ready -> COUNTDOWN; countdown<=COUNTDOWN_SEC, race_time<=0, cs_cnt<=0, sec_cnt<=0.
  - start_e while either ready is low is ignored.
- COUNTDOWN:
  - On sec_tick, countdown decrements.
  - On the sec_tick where countdown==1: countdown<=0 and state<=RACING on the same edge.
  - Button edges are ignored.
- RACING:
  - On each cs_tick, race_time increments, saturating at TIME_MAX.
  - Priority 1, any finish high: go to FINISH. winner = {p2_finish, p1_finish} sampled that cycle (both high -> 3, tie). race_time freezes; a cs_tick in the same cycle is not counted.
  - Priority 2, pause_e: go to PAUSE.
  - start_e is ignored.
- PAUSE:
  - race_time and cs_cnt frozen; finish inputs ignored.
  - pause_e -> RACING.
  - start_e -> IDLE (abort). If pause_e and start_e arrive together, start_e wins.
- FINISH:
  - winner and race_time are held.
  - start_e -> IDLE; other inputs are ignored.
- Outputs are registered; the state change is visible one cycle after the triggering edge cycle.
- race_time arithmetic is unsigned 14-bit and never wraps.

Test Plan:
1. Reset mid-RACING (race_time=57) -> same cycle: state=0, race_time=0, winner=0. Holding btn_start high through reset release -> no transition to SETTING.
2. CLK_FREQ=10_000, COUNTDOWN_SEC=3; IDLE, start pulse, both ready, start pulse -> state=3, countdown=3. countdown=2 after 10_000 cycles, 1 after 20_000, then state=4 and countdown=0 after 30_000.
3. In RACING, 250 cs periods (25_000 cycles at CLK_FREQ=10_000) -> race_time=250. Then pause_e -> state=5. Idle 5_000 cycles -> race_time still 250. pause_e -> state=4, and the next increment comes after the remaining partial period.
4. RACING, p1_finish and p2_finish asserted in the same cycle -> state=6, winner=3. Later toggling of either finish input does not change winner. start_e -> state=0, winner=0.
5. SETTING with p2_ready=0: start pulse -> stays state=1. In PAUSE, pause and start rising in the same cycle -> state=0.
6. Force race_time to 9998 in RACING, then 3 cs_ticks -> race_time=9999, no wrap. p2_finish -> winner=2, race_time=9999.
